inverse_permutation: RTL



---
 rtl/inverse_permutation_pkg.sv | 23 ++
 rtl/inverse_permutation_inv_mapper.sv | 23 ++
 rtl/inverse_permutation.sv | 79 +++++++
 3 files changed

// File: rtl/inverse_permutation_pkg.sv
// Shared definitions for the inverse 5x5 bit-matrix permutation block.
//   stateT     : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_N  : default matrix dimension (state width is N*N)
//   DEFAULT_COUNT : default number of inverse-map applications per run
//   invIndex() : destination bit index of source bit (x,y) under the inverse map
package inverse_permutation_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int DEFAULT_N     = 5;
    localparam int DEFAULT_COUNT = 64;

    // Source bit (x,y), stored at index n*y + x, lands at lane ((x+3y) mod n, x),
    // i.e. at index n*x + ((x+3y) mod n).
    function automatic int invIndex(input int n, input int x, input int y);
        return n * x + ((x + 3 * y) % n);
    endfunction

endpackage

// File: rtl/inverse_permutation_inv_mapper.sv
// Combinational inverse lane-position shuffle for an N x N bit matrix.
//   matrixIn  : N*N-bit state, bit index = N*y + x
//   matrixOut : the same bits after one application of the inverse map
// Pure wiring: every output bit is driven by exactly one input bit.
module inv_mapper
    import inverse_permutation_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N*N-1:0] matrixIn,
    output logic [N*N-1:0] matrixOut
);

    generate
        for (genvar gi = 0; gi < N * N; gi++) begin : genLane
            localparam int SRC_X = gi % N;
            localparam int SRC_Y = gi / N;
            localparam int DST   = invIndex(N, SRC_X, SRC_Y);
            assign matrixOut[DST] = matrixIn[gi];
        end
    endgenerate

endmodule

// File: rtl/inverse_permutation.sv
// Inverse permutation unit: loads an N*N-bit state on start and applies the
// inverse lane map Count times (one per cycle), undoing a forward run of the
// same length.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset, wins in every state
//   start     : run request, only honoured while ready=1
//   matrixIn  : state to invert, bit index = N*y + x
//   ready     : high while idle and able to accept start
//   done      : single-cycle pulse; matrixOut holds the result
//   matrixOut : state register contents
module inverse_permutation
    import inverse_permutation_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int Count = DEFAULT_COUNT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*N-1:0] matrixIn,
    output logic           ready,
    output logic           done,
    output logic [N*N-1:0] matrixOut
);

    // A single-application run still needs one counter bit.
    localparam int CW = (Count > 1) ? $clog2(Count) : 1;
    localparam logic [CW-1:0] LAST = CW'(Count - 1);

    stateT          stateReg;
    logic [N*N-1:0] matrixReg;
    logic [N*N-1:0] mappedNext;
    logic [CW-1:0]  countReg;

    inv_mapper #(.N(N)) uMapper (
        .matrixIn  (matrixReg),
        .matrixOut (mappedNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= IDLE;
            matrixReg <= '0;
            countReg  <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        matrixReg <= matrixIn;
                        countReg  <= '0;
                        stateReg  <= RUN;
                    end
                end
                RUN: begin
                    matrixReg <= mappedNext;
                    // Carry-out of the mod-Count counter marks the final application.
                    if (countReg == LAST) begin
                        countReg <= '0;
                        stateReg <= DONE;
                    end else begin
                        countReg <= countReg + 1'b1;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // Both handshake outputs are plain decodes of the state register.
    assign ready     = (stateReg == IDLE);
    assign done      = (stateReg == DONE);
    assign matrixOut = matrixReg;

endmodule
